// File: rtl/conditioner_pkg.sv
// Shared types and default parameters for the input conditioner.
package conditioner_pkg;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int HOLDOFF_CYCLES_DEF  = 2;
    localparam int CNT_W               = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser bringing an asynchronous level into the clk domain.
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_p;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_p[SYNC_STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Debounces a raw switch level and emits change/edge pulses for a downstream latch.
module input_conditioner
    import conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int HOLDOFF_CYCLES  = HOLDOFF_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic d_out,
    output logic en_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_HOLD = CNT_W'(HOLDOFF_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             s;
    logic             commit;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (btn_in),
        .q    (s)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (s != d_out) begin
                    state_nxt = COUNT;
                    cnt_nxt   = CNT_ONE;
                end
            end
            COUNT: begin
                if (s == d_out) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt >= CNT_LAST) begin
                    commit = 1'b1;
                    if (HOLDOFF_CYCLES == 0) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = HOLDOFF;
                        cnt_nxt   = CNT_HOLD;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            HOLDOFF: begin
                // s is deliberately ignored here; a pending change is picked up from IDLE
                if (cnt <= CNT_ONE) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            d_out      <= 1'b0;
            en_out     <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            en_out     <= commit;
            rise_pulse <= commit & s;
            fall_pulse <= commit & ~s;
            if (commit) begin
                d_out <= s;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_input_conditioner.sv
// Directed table-driven bench for input_conditioner with default parameters.
module tb_input_conditioner;

    logic clk;
    logic reset;
    logic btn_in;
    logic d_out;
    logic en_out;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;

    input_conditioner dut (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .d_out     (d_out),
        .en_out    (en_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected vector layout: {d_out, en_out, rise_pulse, fall_pulse, busy}
    typedef struct {
        logic       rst_n;
        logic       btn;
        int         cycles;
        logic [4:0] exp;
    } row_t;

    row_t       rows[$];
    logic [4:0] exp_q[$];
    int         total;
    int         bad;

    task automatic add(input logic r, input logic b, input int n, input logic [4:0] e);
        row_t t;
        t.rst_n  = r;
        t.btn    = b;
        t.cycles = n;
        t.exp    = e;
        rows.push_back(t);
    endtask

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got d/en/rise/fall/busy=%b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {d_out, en_out, rise_pulse, fall_pulse, busy};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [4:0] e;
        total  = 0;
        bad    = 0;
        reset  = 1'b0;
        btn_in = 1'b1;

        // reset held with btn high, then release: treated as a new rise
        add(1'b0, 1'b1, 3, 5'b00000);
        add(1'b1, 1'b1, 2, 5'b00000);
        add(1'b1, 1'b1, 3, 5'b00001);
        add(1'b1, 1'b1, 1, 5'b11101);
        add(1'b1, 1'b1, 1, 5'b10001);
        add(1'b1, 1'b1, 4, 5'b10000);
        // clean fall
        add(1'b1, 1'b0, 2, 5'b10000);
        add(1'b1, 1'b0, 3, 5'b10001);
        add(1'b1, 1'b0, 1, 5'b01011);
        add(1'b1, 1'b0, 1, 5'b00001);
        add(1'b1, 1'b0, 4, 5'b00000);
        // glitch: 3 cycles high then low, rejected
        add(1'b1, 1'b1, 2, 5'b00000);
        add(1'b1, 1'b1, 1, 5'b00001);
        add(1'b1, 1'b0, 2, 5'b00001);
        add(1'b1, 1'b0, 4, 5'b00000);
        // clean rise, btn held 10 cycles
        add(1'b1, 1'b1, 2, 5'b00000);
        add(1'b1, 1'b1, 3, 5'b00001);
        add(1'b1, 1'b1, 1, 5'b11101);
        add(1'b1, 1'b1, 1, 5'b10001);
        add(1'b1, 1'b1, 3, 5'b10000);
        // clean fall again
        add(1'b1, 1'b0, 2, 5'b10000);
        add(1'b1, 1'b0, 3, 5'b10001);
        add(1'b1, 1'b0, 1, 5'b01011);
        add(1'b1, 1'b0, 1, 5'b00001);
        add(1'b1, 1'b0, 3, 5'b00000);
        // rise, then bounce low for 2 cycles inside holdoff, settle high
        add(1'b1, 1'b1, 2, 5'b00000);
        add(1'b1, 1'b1, 2, 5'b00001);
        add(1'b1, 1'b0, 1, 5'b00001);
        add(1'b1, 1'b0, 1, 5'b11101);
        add(1'b1, 1'b1, 1, 5'b10001);
        add(1'b1, 1'b1, 5, 5'b10000);
        // reset asserted while cnt=2 in COUNT
        add(1'b1, 1'b0, 2, 5'b10000);
        add(1'b1, 1'b0, 2, 5'b10001);
        add(1'b0, 1'b0, 2, 5'b00000);
        add(1'b1, 1'b0, 6, 5'b00000);
        // s changes on the commit edge: rise completes, then a fresh count commits a fall
        add(1'b1, 1'b1, 2, 5'b00000);
        add(1'b1, 1'b1, 2, 5'b00001);
        add(1'b1, 1'b0, 1, 5'b00001);
        add(1'b1, 1'b0, 1, 5'b11101);
        add(1'b1, 1'b0, 1, 5'b10001);
        add(1'b1, 1'b0, 1, 5'b10000);
        add(1'b1, 1'b0, 3, 5'b10001);
        add(1'b1, 1'b0, 1, 5'b01011);
        add(1'b1, 1'b0, 1, 5'b00001);
        add(1'b1, 1'b0, 3, 5'b00000);

        foreach (rows[i]) begin
            for (int c = 0; c < rows[i].cycles; c++) begin
                @(negedge clk);
                reset  = rows[i].rst_n;
                btn_in = rows[i].btn;
                exp_q.push_back(rows[i].exp);
                @(posedge clk);
                #1;
                e = exp_q.pop_front();
                check($sformatf("row%0d_cyc%0d", i, c), outs(), e);
            end
        end

        // asynchronous reset landing on the commit cycle, no clock edge in between
        @(negedge clk);
        btn_in = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("async_pre_commit", outs(), 5'b11101);
        #1;
        reset = 1'b0;
        #1;
        check("async_reset_immediate", outs(), 5'b00000);
        @(negedge clk);
        btn_in = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("async_after_release_%0d", c), outs(), 5'b00000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
